// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: write-back source selects, load/store
// width codes, FSM states and the access-size decode helper.
package mem_stage_pkg;

  localparam logic [1:0] FROM_ALU = 2'd0;
  localparam logic [1:0] FROM_IMM = 2'd1;
  localparam logic [1:0] FROM_MEM = 2'd2;
  localparam logic [1:0] FROM_PC  = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;

  // Unsigned widths only exist for loads; on a store they fall back to word.
  function automatic size_e acc_size(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B:    return SZ_B;
      F3_H:    return SZ_H;
      F3_BU:   return is_store ? SZ_W : SZ_B;
      F3_HU:   return is_store ? SZ_W : SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus: master is the pipeline, slave is the memory.
interface mem_stage_if #(parameter int XLEN = 32);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      wstrb;
  logic [XLEN-1:0] rdata;
  logic            ack;

  modport master (output req, we, addr, wdata, wstrb, input rdata, ack);
  modport slave  (input req, we, addr, wdata, wstrb, output rdata, ack);
endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the byte/half addressed by the byte offset and sign/zero-extends it.
// Purely combinational so a future D-cache can reuse it.
module load_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{(XLEN-8){b[7]}}, b};
      F3_BU:   data = {{(XLEN-8){1'b0}}, b};
      F3_H:    data = {{(XLEN-16){h[15]}}, h};
      F3_HU:   data = {{(XLEN-16){1'b0}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: drives the req/ack data bus, stalls the front of the pipe
// while an access is outstanding, and holds the MEM/WB pipeline register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_mem,
  input  logic                 mem_read_mem,
  input  logic                 mem_write_mem,
  input  logic [2:0]           funct3_mem,
  input  logic [XLEN-1:0]      alu_result_mem,
  input  logic [XLEN-1:0]      rs2_data_mem,
  input  logic                 reg_write_mem,
  input  logic [RF_ADDR_W-1:0] rd_mem,
  input  logic [1:0]           reg_src_mem,
  input  logic [XLEN-1:0]      imm_mem,
  input  logic [XLEN-1:0]      nxpc_mem,
  mem_stage_if.master          dmem,
  output logic                 mem_stall,
  output logic                 misalign_err,
  output logic                 valid_wb,
  output logic                 reg_write_wb,
  output logic [RF_ADDR_W-1:0] rd_wb,
  output logic [1:0]           reg_src_wb,
  output logic [XLEN-1:0]      alu_result_wb,
  output logic [XLEN-1:0]      mem2reg_data_wb,
  output logic [XLEN-1:0]      imm_wb,
  output logic [XLEN-1:0]      nxpc_wb
);

  state_e state_q, state_d;
  size_e  sz;
  logic   acc, mis, issue, idle, busy;

  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [XLEN-1:0] load_data;

  logic                 valid_wb_q, valid_wb_d, reg_write_wb_q, reg_write_wb_d;
  logic [RF_ADDR_W-1:0] rd_wb_q, rd_wb_d;
  logic [1:0]           reg_src_wb_q, reg_src_wb_d;
  logic [XLEN-1:0]      alu_wb_q, alu_wb_d, m2r_wb_q, m2r_wb_d;
  logic [XLEN-1:0]      imm_wb_q, imm_wb_d, nxpc_wb_q, nxpc_wb_d;

  always_comb begin
    idle  = (state_q == IDLE);
    busy  = (state_q == BUSY);
    acc   = valid_mem & (mem_read_mem | mem_write_mem);
    sz    = acc_size(funct3_mem, mem_write_mem);
    mis   = ((sz == SZ_H) & alu_result_mem[0]) |
            ((sz == SZ_W) & (alu_result_mem[1:0] != 2'b00));
    issue = idle & acc & ~mis;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue)    state_d = BUSY;
      BUSY:    if (dmem.ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. Bus fields come from the latched request so they stay
  // stable for the whole BUSY window regardless of what EX/MEM does.
  always_comb begin
    dmem.req     = busy;
    dmem.we      = busy & we_q;
    dmem.addr    = busy ? addr_q  : '0;
    dmem.wdata   = busy ? wdata_q : '0;
    dmem.wstrb   = busy ? wstrb_q : 4'b0000;
    mem_stall    = ~rst & (issue | (busy & ~dmem.ack));
    misalign_err = ~rst & idle & acc & mis;
  end

  // Request capture, with store lane replication and strobe generation
  always_comb begin
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    f3_d    = f3_q;
    off_d   = off_q;
    if (issue) begin
      addr_d  = {alu_result_mem[XLEN-1:2], 2'b00};
      we_d    = mem_write_mem;
      f3_d    = funct3_mem;
      off_d   = alu_result_mem[1:0];
      wdata_d = '0;
      wstrb_d = 4'b0000;
      if (mem_write_mem) begin
        case (sz)
          SZ_B: begin
            wdata_d = {4{rs2_data_mem[7:0]}};
            wstrb_d = 4'b0001 << alu_result_mem[1:0];
          end
          SZ_H: begin
            wdata_d = {2{rs2_data_mem[15:0]}};
            wstrb_d = 4'b0011 << alu_result_mem[1:0];
          end
          default: begin
            wdata_d = rs2_data_mem;
            wstrb_d = 4'b1111;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= 4'b0000;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
    end else begin
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  load_align #(.XLEN(XLEN)) u_align (
    .rdata  (dmem.rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  // MEM/WB: anything other than a pass-through or a completed access is an
  // all-zero bubble. EX/MEM is frozen while BUSY, so its fields are still valid
  // in the ack cycle.
  always_comb begin
    valid_wb_d     = 1'b0;
    reg_write_wb_d = 1'b0;
    rd_wb_d        = '0;
    reg_src_wb_d   = 2'b00;
    alu_wb_d       = '0;
    m2r_wb_d       = '0;
    imm_wb_d       = '0;
    nxpc_wb_d      = '0;
    if ((idle & valid_mem & ~issue) | (busy & dmem.ack)) begin
      valid_wb_d     = 1'b1;
      reg_write_wb_d = reg_write_mem & ~(idle & acc & mis);
      rd_wb_d        = rd_mem;
      reg_src_wb_d   = reg_src_mem;
      alu_wb_d       = alu_result_mem;
      imm_wb_d       = imm_mem;
      nxpc_wb_d      = nxpc_mem;
      if (busy & ~we_q) m2r_wb_d = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_wb_q     <= 1'b0;
      reg_write_wb_q <= 1'b0;
      rd_wb_q        <= '0;
      reg_src_wb_q   <= 2'b00;
      alu_wb_q       <= '0;
      m2r_wb_q       <= '0;
      imm_wb_q       <= '0;
      nxpc_wb_q      <= '0;
    end else begin
      valid_wb_q     <= valid_wb_d;
      reg_write_wb_q <= reg_write_wb_d;
      rd_wb_q        <= rd_wb_d;
      reg_src_wb_q   <= reg_src_wb_d;
      alu_wb_q       <= alu_wb_d;
      m2r_wb_q       <= m2r_wb_d;
      imm_wb_q       <= imm_wb_d;
      nxpc_wb_q      <= nxpc_wb_d;
    end
  end

  assign valid_wb        = valid_wb_q;
  assign reg_write_wb    = reg_write_wb_q;
  assign rd_wb           = rd_wb_q;
  assign reg_src_wb      = reg_src_wb_q;
  assign alu_result_wb   = alu_wb_q;
  assign mem2reg_data_wb = m2r_wb_q;
  assign imm_wb          = imm_wb_q;
  assign nxpc_wb         = nxpc_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single instructions with
// hand-computed results, plus reset-during-BUSY and late-ack sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_mem, mem_read_mem, mem_write_mem, reg_write_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] alu_result_mem, rs2_data_mem, imm_mem, nxpc_mem;
  logic [4:0]  rd_mem;
  logic [1:0]  reg_src_mem;
  logic        mem_stall, misalign_err, valid_wb, reg_write_wb;
  logic [4:0]  rd_wb;
  logic [1:0]  reg_src_wb;
  logic [31:0] alu_result_wb, mem2reg_data_wb, imm_wb, nxpc_wb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_if #(.XLEN(32)) dmem ();

  mem_stage #(.XLEN(32), .RF_ADDR_W(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_mem       (valid_mem),
    .mem_read_mem    (mem_read_mem),
    .mem_write_mem   (mem_write_mem),
    .funct3_mem      (funct3_mem),
    .alu_result_mem  (alu_result_mem),
    .rs2_data_mem    (rs2_data_mem),
    .reg_write_mem   (reg_write_mem),
    .rd_mem          (rd_mem),
    .reg_src_mem     (reg_src_mem),
    .imm_mem         (imm_mem),
    .nxpc_mem        (nxpc_mem),
    .dmem            (dmem),
    .mem_stall       (mem_stall),
    .misalign_err    (misalign_err),
    .valid_wb        (valid_wb),
    .reg_write_wb    (reg_write_wb),
    .rd_wb           (rd_wb),
    .reg_src_wb      (reg_src_wb),
    .alu_result_wb   (alu_result_wb),
    .mem2reg_data_wb (mem2reg_data_wb),
    .imm_wb          (imm_wb),
    .nxpc_wb         (nxpc_wb)
  );

  typedef struct {
    logic        valid, rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, rs2, rdata;
    int          lat;
    logic        rw;
    logic        e_acc, e_mis, e_vwb, e_rw;
    logic [31:0] e_m2r, e_daddr;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    valid_mem = 1'b0; mem_read_mem = 1'b0; mem_write_mem = 1'b0; reg_write_mem = 1'b0;
    funct3_mem = 3'b000; alu_result_mem = '0; rs2_data_mem = '0; imm_mem = '0;
    nxpc_mem = '0; rd_mem = '0; reg_src_mem = FROM_ALU;
  endtask

  // Entered and left at posedge+1.
  task automatic run_vec(input int i, input vec_t v);
    string t;
    int    stalls, reqs;
    t = $sformatf("v%0d", i);
    valid_mem = v.valid; mem_read_mem = v.rd; mem_write_mem = v.wr; funct3_mem = v.f3;
    alu_result_mem = v.addr; rs2_data_mem = v.rs2; reg_write_mem = v.rw;
    rd_mem = 5'(i + 1); reg_src_mem = v.rd ? FROM_MEM : FROM_ALU;
    imm_mem = 32'h55; nxpc_mem = 32'h2000 + 32'(i) * 4;
    stalls = 0; reqs = 0;
    @(negedge clk);
    chk({t, " misalign_err"}, 32'(misalign_err), 32'(v.e_mis));
    chk({t, " issue stall"},  32'(mem_stall),    32'(v.e_acc));
    chk({t, " issue req"},    32'(dmem.req),     32'h0);
    @(posedge clk); #1;
    if (v.e_acc) begin
      for (int c = 1; c <= v.lat; c++) begin
        chk({t, " busy bubble"}, 32'(valid_wb), 32'h0);
        dmem.ack   = (c == v.lat);
        dmem.rdata = (c == v.lat) ? v.rdata : 32'h0BAD0BAD;
        @(negedge clk);
        if (dmem.req)  reqs++;
        if (mem_stall) stalls++;
        chk({t, " addr"},  dmem.addr,       v.e_daddr);
        chk({t, " we"},    32'(dmem.we),    32'(v.e_we));
        chk({t, " wstrb"}, 32'(dmem.wstrb), 32'(v.e_wstrb));
        if (v.wr) chk({t, " wdata"}, dmem.wdata, v.e_wdata);
        @(posedge clk); #1;
        dmem.ack = 1'b0;
      end
      chk({t, " req cycles"},       32'(reqs),   32'(v.lat));
      chk({t, " busy stall cycles"}, 32'(stalls), 32'(v.lat - 1));
    end else begin
      chk({t, " no req"}, 32'(dmem.req), 32'h0);
    end
    chk({t, " valid_wb"},     32'(valid_wb),     32'(v.e_vwb));
    chk({t, " reg_write_wb"}, 32'(reg_write_wb), 32'(v.e_rw));
    chk({t, " mem2reg"},      mem2reg_data_wb,   v.e_m2r);
    if (v.e_vwb) begin
      chk({t, " alu_result_wb"}, alu_result_wb, v.addr);
      chk({t, " rd_wb"},         32'(rd_wb),    32'(i + 1));
      chk({t, " nxpc_wb"},       nxpc_wb,       32'h2000 + 32'(i) * 4);
    end
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            vld rd wr f3      addr          rs2           rdata        lat rw  acc mis vwb rw  m2r           daddr         we wdata         wstrb
    vecs[0]  = '{1, 0, 0, 3'b000, 32'h1234,     32'h0,        32'h0,        0, 1,  0,  0,  1,  1, 32'h0,        32'h0,        0, 32'h0,        4'b0000};
    vecs[1]  = '{1, 1, 0, 3'b010, 32'h100,      32'h0,        32'hDEADBEEF, 3, 1,  1,  0,  1,  1, 32'hDEADBEEF, 32'h100,      0, 32'h0,        4'b0000};
    vecs[2]  = '{1, 1, 0, 3'b000, 32'h103,      32'h0,        32'h80FF0000, 1, 1,  1,  0,  1,  1, 32'hFFFFFF80, 32'h100,      0, 32'h0,        4'b0000};
    vecs[3]  = '{1, 1, 0, 3'b100, 32'h103,      32'h0,        32'h80FF0000, 1, 1,  1,  0,  1,  1, 32'h00000080, 32'h100,      0, 32'h0,        4'b0000};
    vecs[4]  = '{1, 1, 0, 3'b001, 32'h102,      32'h0,        32'h80FF0000, 1, 1,  1,  0,  1,  1, 32'hFFFF80FF, 32'h100,      0, 32'h0,        4'b0000};
    vecs[5]  = '{1, 1, 0, 3'b101, 32'h102,      32'h0,        32'h80FF0000, 2, 1,  1,  0,  1,  1, 32'h000080FF, 32'h100,      0, 32'h0,        4'b0000};
    vecs[6]  = '{1, 0, 1, 3'b000, 32'h101,      32'h000000AB, 32'h0,        1, 0,  1,  0,  1,  0, 32'h0,        32'h100,      1, 32'hABABABAB, 4'b0010};
    vecs[7]  = '{1, 0, 1, 3'b001, 32'h102,      32'h1234CDEF, 32'h0,        2, 0,  1,  0,  1,  0, 32'h0,        32'h100,      1, 32'hCDEFCDEF, 4'b1100};
    vecs[8]  = '{1, 0, 1, 3'b010, 32'h204,      32'hCAFEF00D, 32'h0,        1, 0,  1,  0,  1,  0, 32'h0,        32'h204,      1, 32'hCAFEF00D, 4'b1111};
    vecs[9]  = '{1, 1, 0, 3'b010, 32'h102,      32'h0,        32'h0,        0, 1,  0,  1,  1,  0, 32'h0,        32'h0,        0, 32'h0,        4'b0000};
    vecs[10] = '{1, 1, 0, 3'b001, 32'h101,      32'h0,        32'h0,        0, 1,  0,  1,  1,  0, 32'h0,        32'h0,        0, 32'h0,        4'b0000};
    vecs[11] = '{1, 0, 1, 3'b010, 32'h201,      32'h11223344, 32'h0,        0, 1,  0,  1,  1,  0, 32'h0,        32'h0,        0, 32'h0,        4'b0000};
    vecs[12] = '{0, 1, 0, 3'b010, 32'h100,      32'h0,        32'h0,        0, 1,  0,  0,  0,  0, 32'h0,        32'h0,        0, 32'h0,        4'b0000};
    vecs[13] = '{1, 1, 0, 3'b000, 32'h101,      32'h0,        32'h00007F00, 2, 1,  1,  0,  1,  1, 32'h0000007F, 32'h100,      0, 32'h0,        4'b0000};
    vecs[14] = '{1, 1, 0, 3'b011, 32'h108,      32'h0,        32'h01234567, 1, 1,  1,  0,  1,  1, 32'h01234567, 32'h108,      0, 32'h0,        4'b0000};
    vecs[15] = '{1, 0, 0, 3'b001, 32'h0003,     32'h0,        32'h0,        0, 1,  0,  0,  1,  1, 32'h0,        32'h0,        0, 32'h0,        4'b0000};

    drive_idle();
    dmem.ack = 1'b0; dmem.rdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req",       32'(dmem.req),     32'h0);
    chk("reset stall",     32'(mem_stall),    32'h0);
    chk("reset valid_wb",  32'(valid_wb),     32'h0);
    chk("reset alu_wb",    alu_result_wb,     32'h0);
    chk("reset nxpc_wb",   nxpc_wb,           32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Reset during BUSY, then a late ack while IDLE
    valid_mem = 1'b1; mem_read_mem = 1'b1; funct3_mem = F3_W; alu_result_mem = 32'h100;
    reg_write_mem = 1'b1; rd_mem = 5'd9; reg_src_mem = FROM_MEM; nxpc_mem = 32'h3000;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbusy req before rst", 32'(dmem.req), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    chk("rstbusy req",       32'(dmem.req),       32'h0);
    chk("rstbusy valid_wb",  32'(valid_wb),       32'h0);
    chk("rstbusy rw_wb",     32'(reg_write_wb),   32'h0);
    chk("rstbusy m2r",       mem2reg_data_wb,     32'h0);
    chk("rstbusy stall",     32'(mem_stall),      32'h0);
    rst = 1'b0;
    dmem.ack = 1'b1; dmem.rdata = 32'h11111111;
    @(negedge clk);
    chk("late ack stall",    32'(mem_stall),      32'h0);
    chk("late ack req",      32'(dmem.req),       32'h0);
    @(posedge clk); #1;
    dmem.ack = 1'b0;
    chk("late ack valid_wb", 32'(valid_wb),       32'h0);
    chk("late ack m2r",      mem2reg_data_wb,     32'h0);
    chk("late ack rd_wb",    32'(rd_wb),          32'h0);

    // An ALU op right after must pass straight through, proving the FSM is IDLE
    run_vec(0, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Fourth stage of the five-stage RV32I pipeline. Sits between the EX/MEM register and the write-back mux.
- Performs loads and stores over a req/ack data-memory bus. Aligns and sign-extends load data.
- Contains the MEM/WB pipeline register that drives reg_src_wb, alu_result_wb, mem2reg_data_wb, imm_wb and nxpc_wb into write-back.
- Raises a stall to the hazard unit while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath width.
- RF_ADDR_W, 5, register-file index width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- valid_mem  in  1  EX/MEM holds a live instruction
- mem_read_mem  in  1  instruction is a load
- mem_write_mem  in  1  instruction is a store
- funct3_mem  in  3  access width/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- alu_result_mem  in  XLEN  effective address or ALU result
- rs2_data_mem  in  XLEN  store data
- reg_write_mem  in  1  destination write enable
- rd_mem  in  RF_ADDR_W  destination register
- reg_src_mem  in  2  write-back source select (FROM_ALU/IMM/MEM/PC)
- imm_mem  in  XLEN  immediate
- nxpc_mem  in  XLEN  PC+4
- dmem_req  out  1  bus request
- dmem_we  out  1  write enable
- dmem_addr  out  XLEN  word-aligned address (bits [1:0] = 0)
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_wstrb  out  4  byte strobes
- dmem_rdata  in  XLEN  read data, valid with ack
- dmem_ack  in  1  one-cycle completion pulse
- mem_stall  out  1  freeze IF/ID/EX and EX/MEM
- misalign_err  out  1  one-cycle pulse on a misaligned access
- valid_wb, reg_write_wb, rd_wb, reg_src_wb, alu_result_wb, mem2reg_data_wb, imm_wb, nxpc_wb  out  (1, 1, 5, 2, 32, 32, 32, 32)  MEM/WB register outputs

Behaviour:
- Reset: state IDLE. All outputs, including every MEM/WB output and dmem_*, are 0.
- Reset is synchronous and wins over everything, including an access in BUSY. dmem_req drops in the cycle after the rst edge. A late ack arriving in IDLE is ignored.
- Definitions:
  - acc = valid_mem & (mem_read_mem | mem_write_mem)
  - mis = H with addr[0] ≠ 0, or W with addr[1:0] ≠ 0
- IDLE, no acc: MEM/WB loads the EX/MEM fields in one cycle. mem2reg_data_wb = 0. mem_stall = 0.
- IDLE, acc & mis:
  - No bus request is issued.
  - MEM/WB loads with reg_write_wb forced to 0 and valid_wb = 1.
  - misalign_err = 1 for that cycle. No stall.
- IDLE, acc & !mis:
  - mem_stall = 1; MEM/WB loads a bubble (valid_wb = 0, reg_write_wb = 0).
  - At the clock edge, latch addr/we/wdata/wstrb and funct3/addr[1:0]; go to BUSY.
- BUSY:
  - dmem_req = 1, with all bus fields held stable until ack.
  - mem_stall = !dmem_ack.
  - No ack: MEM/WB loads a bubble.
  - Ack: MEM/WB loads the instruction. For a load, mem2reg_data_wb = aligned dmem_rdata. Return to IDLE.
  - Minimum memory-op latency is 2 cycles (ack in the first BUSY cycle).
- Store formatting:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 0011 << addr[1:0].
  - SW: wdata = rs2, wstrb = 1111.
- Load formatting: select the byte/half using the latched addr[1:0]. Sign-extend for B/H; zero-extend for BU/HU. W passes through.
- Undefined funct3 values: treated as W.
- Loads drive dmem_we = 0 and dmem_wstrb = 0.
- valid_mem = 0 always produces a bubble, and no request is issued.

Decomposition:
- Shared defines file holds:
  - FROM_ALU/IMM/MEM/PC select encodings (already present)
  - new funct3 width encodings F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state encodings IDLE/BUSY
- One combinational sub-module, load_align: inputs rdata, byte offset and funct3; output is the extended value. It is reusable by a future D-cache.

Test Plan:
- ALU op: x5 = 0x1234, reg_src FROM_ALU, no mem access → next cycle valid_wb = 1, alu_result_wb = 0x1234, mem_stall never asserted.
- LW at 0x100, ack on the 3rd BUSY cycle with rdata 0xDEADBEEF:
  - dmem_req high for 3 cycles; mem_stall high for 3 cycles (IDLE issue cycle plus 2 non-ack BUSY cycles), low in the ack cycle.
  - MEM/WB holds bubbles meanwhile.
  - mem2reg_data_wb = 0xDEADBEEF one cycle after the ack.
- LB at 0x103 with rdata 0x80FF_0000 → 0xFFFFFF80. LBU → 0x00000080. LH at 0x102 → 0xFFFF80FF. LHU → 0x000080FF.
- SB at 0x101 with rs2 = 0x000000AB → wstrb = 0010, wdata = 0xABABABAB, dmem_we = 1, dmem_addr = 0x100.
- LW at 0x102 → no dmem_req, misalign_err = 1 for one cycle, reg_write_wb = 0, no stall.
- Assert rst in BUSY before ack → next cycle dmem_req = 0, all WB outputs 0, state IDLE. A later ack does not change any output.
